mem_npr: RTL and testbench

Parametrised simple-dual-port successor memory: one synchronous write port with byte enables, NUM_READ independent asynchronous read ports, a per-entry valid bit array with single-cycle bulk flush, and a post-reset initialisation sweep. It serves as the storage array for reorder-buffer entries, where several commit/issue-side readers inspect slots while one allocator/writeback side writes them.

---
 rtl/mem_npr_pkg.sv | 27 ++
 rtl/mem_npr_valid.sv | 39 +++
 rtl/mem_npr.sv | 101 ++++++++++
 tb/tb_mem_npr.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_npr_pkg.sv
// Shared types and helpers for the mem_npr reorder-buffer storage array.
// merge_be works on a fixed maximum width; callers cast to and from DATA_WIDTH (<= 256).
package mem_npr_pkg;

  typedef enum logic {
    MEM_NPR_INIT  = 1'b0,
    MEM_NPR_READY = 1'b1
  } mem_npr_state_e;

  localparam int unsigned MEM_NPR_MAX_DW = 256;
  localparam int unsigned MEM_NPR_MAX_BE = MEM_NPR_MAX_DW / 8;

  // Replace the bytes of old_data selected by be with the matching bytes of new_data.
  function automatic logic [MEM_NPR_MAX_DW-1:0] merge_be(
    input logic [MEM_NPR_MAX_DW-1:0] old_data,
    input logic [MEM_NPR_MAX_DW-1:0] new_data,
    input logic [MEM_NPR_MAX_BE-1:0] be
  );
    logic [MEM_NPR_MAX_DW-1:0] res;
    res = old_data;
    for (int unsigned b = 0; b < MEM_NPR_MAX_BE; b++) begin
      if (be[b]) res[8*b +: 8] = new_data[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_npr_valid.sv
// Per-entry valid bits: set on write, clear-one during the init sweep, clear-all on flush.
// A set in the same cycle as clear-all wins, so the written entry survives a flush.
module mem_npr_valid #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NUM_READ   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           set_i,
  input  logic [ADDR_WIDTH-1:0]          set_addr_i,
  input  logic                           clr_one_i,
  input  logic [ADDR_WIDTH-1:0]          clr_addr_i,
  input  logic                           clr_all_i,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] lookup_addr_i,
  output logic [NUM_READ-1:0]            valid_o
);

  localparam int unsigned MEM_DEPTH = 2 ** ADDR_WIDTH;

  logic [MEM_DEPTH-1:0] valid_q;
  logic [MEM_DEPTH-1:0] valid_d;

  always_comb begin
    valid_d = valid_q;
    if (clr_all_i) valid_d = '0;
    if (clr_one_i) valid_d[clr_addr_i] = 1'b0;
    if (set_i)     valid_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_lookup
    assign valid_o[k] = valid_q[lookup_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]];
  end

endmodule

// File: rtl/mem_npr.sv
// Reorder-buffer storage: one byte-enabled write port, NUM_READ async read ports,
// valid bits with bulk flush, and a post-reset init sweep. Optional MEM_NPR_BYPASS_EN forwards writes to reads.
module mem_npr
  import mem_npr_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 4,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           NUM_READ   = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           ready_o,
  input  logic                           write_en_i,
  input  logic [DATA_WIDTH/8-1:0]        write_be_i,
  input  logic [ADDR_WIDTH-1:0]          addr_write_i,
  input  logic [DATA_WIDTH-1:0]          data_write_i,
  input  logic                           flush_i,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] addr_read_i,
  output logic [NUM_READ*DATA_WIDTH-1:0] data_read_o,
  output logic [NUM_READ-1:0]            valid_read_o
);

  localparam int unsigned MEM_DEPTH = 2 ** ADDR_WIDTH;

  mem_npr_state_e        state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  ready_q;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                  sweep_c;
  logic                  wr_c;
  logic                  flush_c;
  logic [DATA_WIDTH-1:0] wr_data_c;
  logic [NUM_READ-1:0]   valid_lk_c;

  assign ready_o   = ready_q;
  assign sweep_c   = (state_q == MEM_NPR_INIT) && !rst;
  assign wr_c      = (state_q == MEM_NPR_READY) && write_en_i && !rst;
  assign flush_c   = (state_q == MEM_NPR_READY) && flush_i;
  assign wr_data_c = DATA_WIDTH'(merge_be(MEM_NPR_MAX_DW'(mem_q[addr_write_i]),
                                          MEM_NPR_MAX_DW'(data_write_i),
                                          MEM_NPR_MAX_BE'(write_be_i)));

  // Sweep counter walks every entry once, then the array opens for use.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEM_NPR_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        MEM_NPR_INIT: begin
          cnt_q <= cnt_q + ADDR_WIDTH'(1);
          if (cnt_q == ADDR_WIDTH'(MEM_DEPTH - 1)) begin
            state_q <= MEM_NPR_READY;
            ready_q <= 1'b1;
          end
        end
        default: ready_q <= 1'b1;
      endcase
    end
  end

  // Data array carries no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (sweep_c)   mem_q[cnt_q]        <= INIT_VALUE;
    else if (wr_c) mem_q[addr_write_i] <= wr_data_c;
  end

  mem_npr_valid #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_READ   (NUM_READ)
  ) u_valid (
    .clk           (clk),
    .rst           (rst),
    .set_i         (wr_c),
    .set_addr_i    (addr_write_i),
    .clr_one_i     (sweep_c),
    .clr_addr_i    (cnt_q),
    .clr_all_i     (flush_c),
    .lookup_addr_i (addr_read_i),
    .valid_o       (valid_lk_c)
  );

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr_c;
    assign addr_c = addr_read_i[k*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef MEM_NPR_BYPASS_EN
    logic hit_c;
    assign hit_c = wr_c && (addr_c == addr_write_i);
    assign data_read_o[k*DATA_WIDTH +: DATA_WIDTH] = hit_c ? wr_data_c : mem_q[addr_c];
    assign valid_read_o[k] = hit_c || (ready_q && valid_lk_c[k]);
`else
    assign data_read_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[addr_c];
    assign valid_read_o[k] = ready_q && valid_lk_c[k];
`endif
  end

endmodule

// File: tb/tb_mem_npr.sv
// Scoreboard bench for mem_npr: a reference model of the array predicts each read,
// expectations are queued when read addresses are driven and compared once outputs settle.
module tb_mem_npr;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned NR    = 2;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned NB    = DW / 8;
  localparam logic [DW-1:0] INIT_V = 32'hA5A5_5A5A;

  logic             clk = 1'b0;
  logic             rst;
  logic             ready_o;
  logic             write_en;
  logic [NB-1:0]    write_be;
  logic [AW-1:0]    addr_write;
  logic [DW-1:0]    data_write;
  logic             flush;
  logic [NR*AW-1:0] addr_read;
  logic [NR*DW-1:0] data_read_o;
  logic [NR-1:0]    valid_read_o;

  always #5 clk = ~clk;

  mem_npr #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_READ   (NR),
    .INIT_VALUE (INIT_V)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ready_o      (ready_o),
    .write_en_i   (write_en),
    .write_be_i   (write_be),
    .addr_write_i (addr_write),
    .data_write_i (data_write),
    .flush_i      (flush),
    .addr_read_i  (addr_read),
    .data_read_o  (data_read_o),
    .valid_read_o (valid_read_o)
  );

  typedef struct {
    string         tag;
    int            port;
    logic          chk_data;
    logic [DW-1:0] data;
    logic          valid;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  logic [DW-1:0]    m_mem [DEPTH];
  logic [DEPTH-1:0] m_valid = '0;
  logic             m_ready = 1'b0;
  int               m_cnt   = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_d, input logic [DW-1:0] new_d,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = old_d;
    for (int b = 0; b < NB; b++) if (be[b]) r[8*b +: 8] = new_d[8*b +: 8];
    return r;
  endfunction

  // Advance one clock edge, updating the reference model from the inputs the DUT sampled.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_ready = 1'b0;
      m_cnt   = 0;
    end else if (!m_ready) begin
      m_mem[m_cnt]   = INIT_V;
      m_valid[m_cnt] = 1'b0;
      if (m_cnt == DEPTH - 1) m_ready = 1'b1;
      m_cnt = (m_cnt + 1) % DEPTH;
    end else begin
      if (flush) m_valid = '0;
      if (write_en) begin
        m_mem[addr_write]   = merge(m_mem[addr_write], data_write, write_be);
        m_valid[addr_write] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic set_wr(input logic we, input logic [NB-1:0] be, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic fl);
    write_en   = we;
    write_be   = be;
    addr_write = a;
    data_write = d;
    flush      = fl;
  endtask

  task automatic check_ready(input string tag);
    check_val(tag, DW'(ready_o), DW'(m_ready));
  endtask

  task automatic read_pair(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input string tag);
    logic [AW-1:0] a [NR];
    exp_t e;
    a[0] = a0;
    a[1] = a1;
    addr_read = {a1, a0};
    for (int k = 0; k < NR; k++) begin
      e.tag      = $sformatf("%s.p%0d.a%0d", tag, k, a[k]);
      e.port     = k;
      e.chk_data = m_ready;
      e.data     = m_mem[a[k]];
      e.valid    = m_ready & m_valid[a[k]];
`ifdef MEM_NPR_BYPASS_EN
      if (m_ready && write_en && (a[k] == addr_write)) begin
        e.data  = merge(m_mem[a[k]], data_write, write_be);
        e.valid = 1'b1;
      end
`endif
      sbq.push_back(e);
    end
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.chk_data) check_val({e.tag, ".data"}, data_read_o[e.port*DW +: DW], e.data);
      check_val({e.tag, ".valid"}, DW'(valid_read_o[e.port]), DW'(e.valid));
    end
  endtask

  task automatic scan_all(input string tag);
    for (int i = 0; i < DEPTH; i++) read_pair(AW'(i), AW'(DEPTH - 1 - i), tag);
  endtask

  task automatic sweep_with_junk(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      set_wr(1'b1, 4'hF, AW'($urandom_range(0, DEPTH - 1)), $urandom, 1'b1);
      read_pair(AW'(i), AW'(4), tag);
      tick();
      check_ready({tag, ".ready"});
    end
    set_wr(1'b0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    addr_read = '0;
    set_wr(1'b0, '0, '0, '0, 1'b0);
    tick();
    tick();
    check_val("reset_ready", DW'(ready_o), '0);

    rst = 1'b0;
    sweep_with_junk("sweep0");
    check_val("ready_after_sweep", DW'(ready_o), 32'd1);
    scan_all("post_init");

    set_wr(1'b1, 4'hF, 4'd3, 32'hDEAD_BEEF, 1'b0);
    tick();
    set_wr(1'b1, 4'h1, 4'd3, 32'h0000_00AA, 1'b0);
    tick();
    set_wr(1'b0, '0, '0, '0, 1'b0);
    read_pair(4'd3, 4'd3, "be_merge");
    check_val("be_merge_const", data_read_o[DW-1:0], 32'hDEAD_BEAA);

    set_wr(1'b1, 4'hF, 4'd1, 32'h1111_1111, 1'b0);
    tick();
    set_wr(1'b1, 4'hF, 4'd2, 32'h2222_2222, 1'b0);
    tick();
    set_wr(1'b1, 4'hF, 4'd5, 32'h5555_5555, 1'b1);
    tick();
    set_wr(1'b0, '0, '0, '0, 1'b0);
    read_pair(4'd1, 4'd2, "flush");
    read_pair(4'd5, 4'd3, "flush_wr");

    set_wr(1'b1, 4'hF, 4'd7, 32'h7777_0007, 1'b0);
    tick();
    set_wr(1'b1, 4'hF, 4'd0, 32'h0000_F00D, 1'b0);
    tick();
    set_wr(1'b0, '0, '0, '0, 1'b0);
    read_pair(4'd7, 4'd7, "same_addr");
    read_pair(4'd7, 4'd0, "indep");

    set_wr(1'b1, 4'hF, 4'd9, 32'h9999_0000, 1'b0);
    tick();
    set_wr(1'b1, 4'b0011, 4'd9, 32'h0000_1234, 1'b1);
    read_pair(4'd9, 4'd2, "rw_same_cycle");
    tick();
    set_wr(1'b0, '0, '0, '0, 1'b0);
    read_pair(4'd9, 4'd9, "rw_after");

    set_wr(1'b1, 4'h0, 4'd10, 32'hFFFF_FFFF, 1'b0);
    tick();
    set_wr(1'b0, '0, '0, '0, 1'b0);
    read_pair(4'd10, 4'd10, "be_zero");

    repeat (300) begin
      set_wr(1'($urandom_range(0, 1)), NB'($urandom), AW'($urandom), $urandom,
             ($urandom_range(0, 7) == 0));
      read_pair(AW'($urandom), AW'($urandom), "rand");
      tick();
    end
    set_wr(1'b0, '0, '0, '0, 1'b0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_wr(1'b1, 4'hF, AW'(i), 32'hBAD0_0000 | i, 1'b0);
      tick();
      check_ready("midsweep.ready");
    end
    rst = 1'b1;
    tick();
    check_ready("midsweep_rst.ready");
    rst = 1'b0;
    sweep_with_junk("sweep1");
    scan_all("after_sweep1");

    set_wr(1'b1, 4'hF, 4'd12, 32'hCAFE_CAFE, 1'b0);
    tick();
    set_wr(1'b0, '0, '0, '0, 1'b0);
    read_pair(4'd12, 4'd12, "pre_rst");
    rst = 1'b1;
    tick();
    check_val("ready_drop", DW'(ready_o), '0);
    rst = 1'b0;
    sweep_with_junk("sweep2");
    scan_all("after_sweep2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
